tproc_top: RTL and testbench
============================

Name: tproc_top

Overview:
- Top level of the ternary-weight CNN processing core.
- Fetches 64-bit instructions from an external instruction memory and reads 128-bit feature words and 64-bit weight words from external memories.
- Runs an 8-lane ternary multiply-accumulate and emits a scaled 16-bit result on `scaled_feature`.
- Started by `acc_enable`. Sits between the host-loaded DDR-style memories and downstream feature storage.

Parameters:
- FW, 16, feature lane width (signed).
- LANES, 8, features per feature word (LANES*FW = 128).
- ACC_W, 24, accumulator width (signed).
- PC_W, 8, instruction address width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fast_clk  in  1  reserved; ignored, no logic clocked by it.
- i_data_bus_port  in  128  feature read data.
- i_feature_addr  out  16  feature word address.
- i_feature_rd_en  out  1  feature read strobe.
- i_w_bus_port  in  64  weight read data.
- i_w_addr  out  16  weight word address.
- i_w_enable  out  1  weight read strobe.
- instr_port  in  64  instruction read data.
- instr_fetch_addr  out  8  instruction address (PC).
- instr_rd_en  out  1  instruction read strobe.
- scaled_feature  out  16  signed scaled result, registered.
- acc_enable  in  1  start request.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, PC=0, acc=0, feature/weight regs=0. All outputs 0, including strobes, addresses and `scaled_feature`.
- Memory read protocol, used for instr/feature/weight alike:
  - Cycle N: strobe=1, address driven.
  - Cycle N+1: strobe=0, address held.
  - Data captured at the clock edge ending N+1.
  - Works with combinational or 1-cycle registered memories.
- FSM states: IDLE, FETCH, WAIT_I, EXEC, RD_MEM, WAIT_MEM, HALTED->IDLE.
  - IDLE: `acc_enable`=1 sampled high -> FETCH with PC=0.
  - FETCH -> WAIT_I -> EXEC; instr latched.
  - EXEC performs the op, PC<=PC+1 (wraps 255->0), then -> FETCH unless noted.
  - `acc_enable` is ignored outside IDLE.
- Instruction format: opcode = instr[63:60].
  - 0x0 NOP.
  - 0x1 LDF: RD_MEM/WAIT_MEM on the feature port at addr instr[15:0]; the word goes to the feature reg. Lane i = bits[16i+15:16i].
  - 0x2 LDW: same on the weight port; the word goes to the weight reg.
  - 0x3 CONV:
    - sum = Σ_{i=0..7} t_i·f_i, where t_i is decoded from weight bits[2i+1:2i]: 00=0, 01=+1, 11=-1, 10=0.
    - instr[0]=0: acc<=sum.
    - instr[0]=1: acc<=acc+sum.
    - 24-bit two's complement, wraps on overflow. Single cycle.
  - 0x4 SCALE:
    - p = acc × instr[15:0] (signed, 40-bit), then arithmetic shift right by instr[20:16].
    - `scaled_feature`<=p reduced to 16 bits (see optional feature), updated at the end of EXEC.
  - 0xF HALT: PC<=0, -> IDLE.
  - Other opcodes: treated as NOP.
- Latency:
  - NOP/CONV/SCALE: 3 cycles each.
  - LDF/LDW: 5 cycles each.
- Weight bits[63:16] unused.
- `scaled_feature` holds its value until the next SCALE or reset.
- A program with no HALT runs forever, PC wrapping.
- Reset mid-operation: strobes drop immediately (async), FSM returns to IDLE.

Optional Feature:
- Macro: TPROC_SCALE_SAT_EN.
- Defined: the SCALE result saturates to [-32768, 32767].
- Undefined: the SCALE result is truncated to the low 16 bits (wraps).

Decomposition:
- Package tproc_pkg holds:
  - opcode localparams (OP_NOP, OP_LDF, OP_LDW, OP_CONV, OP_SCALE, OP_HALT);
  - the FSM state enum;
  - the width constants FW, LANES, ACC_W;
  - the ternary code constants.
- One sub-module, ternary_mac8: combinational 8-lane ternary dot product (128-bit features, 16-bit weight codes -> 24-bit signed sum).

Test Plan:
- Reset: hold rst=0 with `acc_enable`=1 -> all strobes 0, `scaled_feature`=0, no fetch. Release rst -> IDLE until `acc_enable` goes high.
- Positive weights:
  - Feature[0] lanes = 1..8, weight[0]=0x5555.
  - Program LDF 0, LDW 0, CONV(clear), SCALE(scale=1, shift=0), HALT.
  - Expect `scaled_feature`=36.
  - Expect `instr_fetch_addr` sequence 0..4, each strobe high exactly one cycle.
- Negative/mixed weights:
  - Weight=0xFFFF with scale=2, shift=1 -> -36.
  - Weight=0x9D5C, i.e. codes lanes0..7 = 0,3,1,1,1,3,1,2 (lane0=0, lane1=-1, lane2..4=+1, lane5=-1, lane6=+1, lane7=0) -> sum = -2+3+4+5-6+7 = 11.
  - CONV accumulate twice -> `scaled_feature`=22.
- Saturation:
  - Lanes all 0x7FFF, weight 0x5555, scale 0x7FFF, shift 0.
  - With TPROC_SCALE_SAT_EN -> 32767.
  - Without -> low 16 bits of the product.
- Control:
  - `acc_enable` pulsed mid-program is ignored.
  - After HALT, a new `acc_enable` restarts at PC=0.
  - Unknown opcode 0x7 behaves as NOP.
- Async reset during LDF WAIT_MEM -> `i_feature_rd_en`/addresses zero immediately, and the next start runs cleanly from PC=0.

Source files
------------

// File: rtl/tproc_pkg.sv
// Shared constants, opcodes, ternary codes and FSM state
// encoding for the ternary-weight CNN processing core.
package tproc_pkg;

    localparam int FW     = 16;
    localparam int LANES  = 8;
    localparam int ACC_W  = 24;
    localparam int PC_W   = 8;
    localparam int PROD_W = 40;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDF   = 4'h1;
    localparam logic [3:0] OP_LDW   = 4'h2;
    localparam logic [3:0] OP_CONV  = 4'h3;
    localparam logic [3:0] OP_SCALE = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] T_ZERO = 2'b00;
    localparam logic [1:0] T_POS  = 2'b01;
    localparam logic [1:0] T_RSV  = 2'b10;
    localparam logic [1:0] T_NEG  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_I,
        S_EXEC,
        S_RD_MEM,
        S_WAIT_MEM,
        S_HALTED
    } state_t;

endpackage

// File: rtl/tproc_top_ternary_mac8.sv
// Combinational 8-lane ternary dot product:
// 16-bit signed lanes times {-1,0,+1} codes into a 24-bit sum.
module ternary_mac8
    import tproc_pkg::*;
(
    input  logic [LANES*FW-1:0]       i_feat,
    input  logic [2*LANES-1:0]        i_codes,
    output logic signed [ACC_W-1:0]   o_sum
);

    logic signed [ACC_W-1:0] w_ext;

    // Sign-extend each lane and add, subtract or skip it by its code
    always_comb begin
        o_sum = '0;
        w_ext = '0;
        for (int i = 0; i < LANES; i++) begin
            w_ext = {{(ACC_W-FW){i_feat[i*FW+FW-1]}},
                     i_feat[i*FW +: FW]};
            case (i_codes[2*i +: 2])
                T_POS:   o_sum = o_sum + w_ext;
                T_NEG:   o_sum = o_sum - w_ext;
                default: o_sum = o_sum;
            endcase
        end
    end

endmodule

// File: rtl/tproc_top.sv
// Ternary CNN core top: fetch/exec FSM, memory strobes, MAC and SCALE.
// Define TPROC_SCALE_SAT_EN to saturate SCALE results instead of wrapping.
module tproc_top
    import tproc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               fast_clk,
    input  logic [127:0]       i_data_bus_port,
    output logic [15:0]        i_feature_addr,
    output logic               i_feature_rd_en,
    input  logic [63:0]        i_w_bus_port,
    output logic [15:0]        i_w_addr,
    output logic               i_w_enable,
    input  logic [63:0]        instr_port,
    output logic [PC_W-1:0]    instr_fetch_addr,
    output logic               instr_rd_en,
    output logic signed [15:0] scaled_feature,
    input  logic               acc_enable
);

    state_t                   r_state;
    state_t                   w_next;
    logic [PC_W-1:0]          r_pc;
    logic [63:0]              r_instr;
    logic [LANES*FW-1:0]      r_feat;
    logic [2*LANES-1:0]       r_weight;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [15:0]       r_scaled;

    logic [3:0]               w_op;
    logic                     w_mem_phase;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [PROD_W-1:0] w_acc_x;
    logic signed [PROD_W-1:0] w_scl_x;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_shr;
    logic signed [15:0]       w_scaled;
    logic                     w_unused_bits;

    localparam logic signed [PROD_W-1:0] SAT_MAX = 40'sd32767;
    localparam logic signed [PROD_W-1:0] SAT_MIN = -40'sd32768;

    assign w_op        = r_instr[63:60];
    assign w_mem_phase = (r_state == S_RD_MEM) || (r_state == S_WAIT_MEM);

    ternary_mac8 u_mac (
        .i_feat  (r_feat),
        .i_codes (r_weight),
        .o_sum   (w_sum)
    );

    assign w_acc_x = {{(PROD_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_scl_x = {{(PROD_W-16){r_instr[15]}}, r_instr[15:0]};
    assign w_prod  = w_acc_x * w_scl_x;
    assign w_shr   = w_prod >>> r_instr[20:16];

`ifdef TPROC_SCALE_SAT_EN
    // Clamp the shifted product into the signed 16-bit range
    always_comb begin
        if (w_shr > SAT_MAX)
            w_scaled = 16'sh7FFF;
        else if (w_shr < SAT_MIN)
            w_scaled = -16'sh8000;
        else
            w_scaled = w_shr[15:0];
    end
`else
    // Keep only the low 16 bits; overflow wraps
    always_comb begin
        w_scaled = w_shr[15:0];
    end
`endif

    assign w_unused_bits = ^{fast_clk, i_w_bus_port[63:16],
                             r_instr[59:21], w_shr, SAT_MAX, SAT_MIN};

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode and memory strobe/address outputs
    always_comb begin
        w_next           = r_state;
        instr_rd_en      = 1'b0;
        instr_fetch_addr = r_pc;
        i_feature_rd_en  = 1'b0;
        i_feature_addr   = '0;
        i_w_enable       = 1'b0;
        i_w_addr         = '0;
        case (r_state)
            S_IDLE: begin
                if (acc_enable)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                instr_rd_en = 1'b1;
                w_next      = S_WAIT_I;
            end
            S_WAIT_I: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_op == OP_LDF || w_op == OP_LDW)
                    w_next = S_RD_MEM;
                else if (w_op == OP_HALT)
                    w_next = S_IDLE;
                else
                    w_next = S_FETCH;
            end
            S_RD_MEM: begin
                w_next = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                w_next = S_FETCH;
            end
            S_HALTED: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_mem_phase && w_op == OP_LDF) begin
            i_feature_addr  = r_instr[15:0];
            i_feature_rd_en = (r_state == S_RD_MEM);
        end
        if (w_mem_phase && w_op == OP_LDW) begin
            i_w_addr   = r_instr[15:0];
            i_w_enable = (r_state == S_RD_MEM);
        end
    end

    // Datapath: PC, instruction latch, operand loads, accumulate, scale
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= '0;
            r_instr  <= '0;
            r_feat   <= '0;
            r_weight <= '0;
            r_acc    <= '0;
            r_scaled <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (acc_enable)
                        r_pc <= '0;
                end
                S_WAIT_I: begin
                    r_instr <= instr_port;
                end
                S_EXEC: begin
                    if (w_op == OP_HALT)
                        r_pc <= '0;
                    else
                        r_pc <= r_pc + 1'b1;
                    if (w_op == OP_CONV)
                        r_acc <= r_instr[0] ? r_acc + w_sum : w_sum;
                    if (w_op == OP_SCALE)
                        r_scaled <= w_scaled;
                end
                S_WAIT_MEM: begin
                    if (w_op == OP_LDF)
                        r_feat <= i_data_bus_port;
                    if (w_op == OP_LDW)
                        r_weight <= i_w_bus_port[15:0];
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    assign scaled_feature = r_scaled;

endmodule

// File: tb/tb_tproc_top.sv
// Directed bench for tproc_top: runs small programs from a
// combinational instruction/feature/weight memory model.
module tb_tproc_top;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         fast_clk = 1'b0;
    logic [127:0] i_data_bus_port;
    logic [15:0]  i_feature_addr;
    logic         i_feature_rd_en;
    logic [63:0]  i_w_bus_port;
    logic [15:0]  i_w_addr;
    logic         i_w_enable;
    logic [63:0]  instr_port;
    logic [7:0]   instr_fetch_addr;
    logic         instr_rd_en;
    logic [15:0]  scaled_feature;
    logic         acc_enable = 1'b0;

    logic [63:0]  imem [256];
    logic [127:0] fmem [256];
    logic [63:0]  wmem [256];

    logic [7:0]   fetch_q [$];
    int           b2b;
    logic         prev_i, prev_f, prev_w;
    int           n_tot = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;
    always #2 fast_clk = ~fast_clk;

    assign instr_port      = imem[instr_fetch_addr];
    assign i_data_bus_port = fmem[i_feature_addr[7:0]];
    assign i_w_bus_port    = wmem[i_w_addr[7:0]];

    tproc_top dut (
        .clk              (clk),
        .rst              (rst),
        .fast_clk         (fast_clk),
        .i_data_bus_port  (i_data_bus_port),
        .i_feature_addr   (i_feature_addr),
        .i_feature_rd_en  (i_feature_rd_en),
        .i_w_bus_port     (i_w_bus_port),
        .i_w_addr         (i_w_addr),
        .i_w_enable       (i_w_enable),
        .instr_port       (instr_port),
        .instr_fetch_addr (instr_fetch_addr),
        .instr_rd_en      (instr_rd_en),
        .scaled_feature   (scaled_feature),
        .acc_enable       (acc_enable)
    );

    // Record fetch addresses and flag any strobe held two cycles
    always @(negedge clk) begin
        if (rst && instr_rd_en)
            fetch_q.push_back(instr_fetch_addr);
        if ((instr_rd_en && prev_i) || (i_feature_rd_en && prev_f) ||
            (i_w_enable && prev_w))
            b2b = b2b + 1;
        prev_i = instr_rd_en;
        prev_f = i_feature_rd_en;
        prev_w = i_w_enable;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] op,
                                       input logic [20:0] arg);
        return {op, 39'd0, arg};
    endfunction

    task automatic run_prog(input string tag, input int halt_pc,
                            input bit pulse);
        bit found;
        found = 1'b0;
        fetch_q.delete();
        b2b = 0;
        @(posedge clk); #1 acc_enable = 1'b1;
        @(posedge clk); #1 acc_enable = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pulse && i == 10) acc_enable = 1'b1;
            if (pulse && i == 11) acc_enable = 1'b0;
            if (instr_rd_en && instr_fetch_addr == 8'(halt_pc)) begin
                found = 1'b1;
                break;
            end
        end
        acc_enable = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, "_halt_seen"}, 64'(found), 64'd1);
        chk({tag, "_b2b"}, 64'(b2b), 64'd0);
    endtask

    task automatic chk_seq(input string tag, input int n);
        chk({tag, "_nfetch"}, 64'(fetch_q.size()), 64'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_pc%0d", tag, i),
                (i < fetch_q.size()) ? 64'(fetch_q[i]) : 64'hFF,
                64'(i));
    endtask

    task automatic load_p1(input logic [20:0] w_addr,
                           input logic [20:0] scl);
        imem[0] = mk(4'h1, 21'd0);
        imem[1] = mk(4'h2, w_addr);
        imem[2] = mk(4'h3, 21'd0);
        imem[3] = mk(4'h4, scl);
        imem[4] = mk(4'hF, 21'd0);
    endtask

    initial begin
        b2b = 0;
        prev_i = 1'b0; prev_f = 1'b0; prev_w = 1'b0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = 64'd0;
            fmem[i] = 128'd0;
            wmem[i] = 64'd0;
        end
        fmem[0] = {16'd8, 16'd7, 16'd6, 16'd5,
                   16'd4, 16'd3, 16'd2, 16'd1};
        fmem[1] = {8{16'h7FFF}};
        wmem[0] = 64'h5555;
        wmem[1] = 64'hFFFF;
        wmem[2] = 64'h9D5C;

        // Reset held with start requested
        rst = 1'b0;
        acc_enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_irden", 64'(instr_rd_en), 64'd0);
        chk("rst_frden", 64'(i_feature_rd_en), 64'd0);
        chk("rst_wen", 64'(i_w_enable), 64'd0);
        chk("rst_pc", 64'(instr_fetch_addr), 64'd0);
        chk("rst_sf", 64'(scaled_feature), 64'd0);
        acc_enable = 1'b0;
        rst = 1'b1;
        fetch_q.delete();
        repeat (5) @(negedge clk);
        chk("idle_nofetch", 64'(fetch_q.size()), 64'd0);

        // Positive weights: 1+..+8 = 36
        load_p1(21'd0, 21'h00001);
        run_prog("pos", 4, 1'b0);
        chk_seq("pos", 5);
        chk("pos_sf", 64'(scaled_feature), 64'd36);
        repeat (6) @(negedge clk);
        chk("pos_hold", 64'(scaled_feature), 64'd36);

        // All -1 weights: -36 * 2 >>> 1 = -36
        load_p1(21'd1, 21'h10002);
        run_prog("neg", 4, 1'b0);
        chk("neg_sf", 64'(scaled_feature), 64'hFFDC);

        // Mixed weights, two CONVs, unknown op, mid-run start pulse
        imem[0] = mk(4'h1, 21'd0);
        imem[1] = mk(4'h2, 21'd2);
        imem[2] = mk(4'h3, 21'd0);
        imem[3] = mk(4'h3, 21'd1);
        imem[4] = mk(4'h7, 21'd0);
        imem[5] = mk(4'h0, 21'd0);
        imem[6] = mk(4'h4, 21'h00001);
        imem[7] = mk(4'hF, 21'd0);
        run_prog("mix", 7, 1'b1);
        chk_seq("mix", 8);
        chk("mix_sf", 64'(scaled_feature), 64'd22);

        // Large product: saturates or wraps to low 16 bits
        imem[0] = mk(4'h1, 21'd1);
        imem[1] = mk(4'h2, 21'd0);
        imem[2] = mk(4'h3, 21'd0);
        imem[3] = mk(4'h4, 21'h07FFF);
        imem[4] = mk(4'hF, 21'd0);
        run_prog("sat", 4, 1'b0);
`ifdef TPROC_SCALE_SAT_EN
        chk("sat_sf", 64'(scaled_feature), 64'h7FFF);
`else
        chk("sat_sf", 64'(scaled_feature), 64'h0008);
`endif

        // Reset during LDF wait phase
        begin
            bit seen;
            seen = 1'b0;
            imem[0] = mk(4'h1, 21'd1);
            imem[1] = mk(4'hF, 21'd0);
            @(posedge clk); #1 acc_enable = 1'b1;
            @(posedge clk); #1 acc_enable = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (i_feature_rd_en) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("rdm_seen", 64'(seen), 64'd1);
            @(posedge clk); #1;
            chk("wm_addr", 64'(i_feature_addr), 64'd1);
            rst = 1'b0;
            #1;
            chk("ar_frden", 64'(i_feature_rd_en), 64'd0);
            chk("ar_faddr", 64'(i_feature_addr), 64'd0);
            chk("ar_pc", 64'(instr_fetch_addr), 64'd0);
            chk("ar_sf", 64'(scaled_feature), 64'd0);
            repeat (2) @(negedge clk);
            rst = 1'b1;
        end

        // Clean restart from PC 0
        load_p1(21'd0, 21'h00001);
        run_prog("rerun", 4, 1'b0);
        chk_seq("rerun", 5);
        chk("rerun_sf", 64'(scaled_feature), 64'd36);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
